// File: rtl/fetch_req_ctrl_pkg.sv
// Shared widths and PC helpers for the fetch request sequencer.
package fetch_req_ctrl_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [ILEN-1:0] insn_t;

  localparam addr_t INSN_BYTES = addr_t'(ILEN / 8);

  function automatic addr_t word_align(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  // Wraps modulo 2^XLEN by construction of the addition width.
  function automatic addr_t next_pc(input addr_t pc);
    return pc + INSN_BYTES;
  endfunction

endpackage

// File: rtl/fetch_credit_cnt.sv
// Up/down counter with synchronous clear and load; clear beats load beats count.
module fetch_credit_cnt
  import fetch_req_ctrl_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i != dec_i) begin
      cnt_d = inc_i ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_req_ctrl.sv
// Fetch sequencer between I$ and fetch FIFO: credit/outstanding-limited requests,
// in-order response push with PC, and flush-kill of in-flight responses.
//
// state | meaning
// IDLE  | no fetching; waits for en_i, then loads boot PC
// FETCH | issuing requests while credits and outstanding cap allow
// DRAIN | en_i low; no new requests, waits for outstanding responses
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [XLEN-1:0] boot_addr_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_addr_i,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_addr_o,
  input  logic            fetch_gnt_i,
  input  logic            fetch_rvalid_i,
  input  logic [ILEN-1:0] fetch_rdata_i,
  output logic            push_o,
  output logic [XLEN-1:0] push_addr_o,
  output logic [ILEN-1:0] push_data_o,
  input  logic            pop_i
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  fsm_e             state_q, state_d;
  addr_t            req_pc_q, req_pc_d;
  addr_t            rsp_pc_q, rsp_pc_d;
  logic [OCC_W-1:0] occ_q;
  logic [OUT_W-1:0] outst_q, kill_q, live, kill_ld_val;
  logic [31:0]      credit_used;
  logic             gnt_cnt, req_fire, kill_dec;

  assign live        = outst_q - kill_q;
  assign credit_used = 32'(occ_q) + 32'(live);

  assign fetch_req_o = (state_q == FETCH) & ~flush_i
                     & (credit_used < FIFO_DEPTH)
                     & (32'(outst_q) < MAX_OUTSTANDING);
  assign fetch_addr_o = req_pc_q;
  assign req_fire     = fetch_req_o & fetch_gnt_i;

  // The request is withdrawn during flush, but an I$ that accepts it anyway
  // has a real transaction in flight; count it so it gets killed.
  assign gnt_cnt = fetch_gnt_i & (fetch_req_o | flush_i);

  assign push_o      = fetch_rvalid_i & (kill_q == '0) & ~flush_i;
  assign push_addr_o = rsp_pc_q;
  assign push_data_o = push_o ? fetch_rdata_i : '0;

  assign kill_dec    = fetch_rvalid_i & (kill_q != '0) & ~flush_i;
  assign kill_ld_val = outst_q + OUT_W'(gnt_cnt) - OUT_W'(fetch_rvalid_i);

  fetch_credit_cnt #(.W(OCC_W)) u_occ_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (flush_i),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (push_o),
    .dec_i    (pop_i),
    .cnt_o    (occ_q)
  );

  fetch_credit_cnt #(.W(OUT_W)) u_outst_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (1'b0),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (gnt_cnt),
    .dec_i    (fetch_rvalid_i),
    .cnt_o    (outst_q)
  );

  fetch_credit_cnt #(.W(OUT_W)) u_kill_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (1'b0),
    .ld_i     (flush_i),
    .ld_val_i (kill_ld_val),
    .inc_i    (1'b0),
    .dec_i    (kill_dec),
    .cnt_o    (kill_q)
  );

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    if (flush_i) begin
      req_pc_d = word_align(flush_addr_i);
      rsp_pc_d = word_align(flush_addr_i);
    end else begin
      if (req_fire) req_pc_d = next_pc(req_pc_q);
      if (push_o)   rsp_pc_d = next_pc(rsp_pc_q);
      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            state_d  = FETCH;
            req_pc_d = word_align(boot_addr_i);
            rsp_pc_d = word_align(boot_addr_i);
          end
        end
        FETCH: begin
          if (!en_i) state_d = DRAIN;
        end
        DRAIN: begin
          if (en_i)                 state_d = FETCH;
          else if (outst_q == '0)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      rsp_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
    end
  end

  pop_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && (occ_q == '0)));

  credit_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_used <= FIFO_DEPTH);

endmodule
